// File: rtl/sobel_pkg.sv
// Shared constants, state type and pixel helpers for the Sobel edge detector.
package sobel_pkg;

  localparam int GRAY_W = 8;
  localparam int GRAD_W = 11;

  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  localparam logic [15:0] EDGE_PIX = 16'hFFFF;
  localparam logic [15:0] BG_PIX   = 16'h0000;

  typedef enum logic {IDLE, FRAME} state_t;

  // Channels are widened by bit replication; the weights sum to 256 so the
  // 16-bit weighted sum cannot overflow.
  function automatic logic [GRAY_W-1:0] rgb565_to_gray(input logic [15:0] p);
    logic [7:0]  r8, g8, b8;
    logic [15:0] sum;
    r8  = {p[15:11], p[15:13]};
    g8  = {p[10:5], p[10:9]};
    b8  = {p[4:0], p[4:2]};
    sum = COEF_R * {8'd0, r8} + COEF_G * {8'd0, g8} + COEF_B * {8'd0, b8};
    return sum[15:8];
  endfunction

  function automatic logic [15:0] gray_to_565(input logic [GRAY_W-1:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

  function automatic logic [GRAD_W-1:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of gray pixels; asynchronous read so the old word is seen
// in the same cycle it is overwritten.
module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_edge_detect.sv
// RGB565 stream -> gray -> 3x3 Sobel -> binary edge map (or gray565 bypass),
// four register stages from accepted input to output.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int                COL    = 640,
  parameter int                ROW    = 480,
  parameter logic [GRAD_W-1:0] THRESH = 11'd48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bypass,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop
);

  localparam int XW = (COL > 1) ? $clog2(COL) : 1;
  localparam int YW = (ROW > 1) ? $clog2(ROW) : 1;

  // Stream semantics: a beat transfers on every cycle with *_vld high; there
  // is no ready, so the consumer must take every dout_vld beat.
  typedef struct packed {
    state_t        state;
    logic          byp;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } ctrl_t;

  ctrl_t         ctrl_q, ctrl_d;
  logic          accept, cur_byp;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl_q <= '{state: IDLE, byp: 1'b0, x: '0, y: '0};
    else     ctrl_q <= ctrl_d;
  end

  // A sop beat is always accepted and restarts the frame at (0,0).
  always_comb begin
    ctrl_d  = ctrl_q;
    accept  = 1'b0;
    cur_x   = ctrl_q.x;
    cur_y   = ctrl_q.y;
    cur_byp = ctrl_q.byp;
    if (din_vld && (din_sop || ctrl_q.state == FRAME)) begin
      accept = 1'b1;
      if (din_sop) begin
        cur_x   = '0;
        cur_y   = '0;
        cur_byp = bypass;
      end
      ctrl_d.byp   = cur_byp;
      ctrl_d.state = din_eop ? IDLE : FRAME;
      if (cur_x == XW'(COL - 1)) begin
        ctrl_d.x = '0;
        ctrl_d.y = (cur_y == YW'(ROW - 1)) ? '0 : cur_y + 1'b1;
      end else begin
        ctrl_d.x = cur_x + 1'b1;
        ctrl_d.y = cur_y;
      end
    end
  end

  logic              s1_vld, s1_sop, s1_eop, s1_byp;
  logic [XW-1:0]     s1_x;
  logic [YW-1:0]     s1_y;
  logic [GRAY_W-1:0] s1_gray;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_sop <= 1'b0; s1_eop <= 1'b0; s1_byp <= 1'b0;
      s1_x <= '0; s1_y <= '0; s1_gray <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_sop  <= din_sop;
        s1_eop  <= din_eop;
        s1_byp  <= cur_byp;
        s1_x    <= cur_x;
        s1_y    <= cur_y;
        s1_gray <= rgb565_to_gray(din);
      end
    end
  end

  logic [GRAY_W-1:0] lb0_rd, lb1_rd;

  // lb1 holds the previous line, lb0 the one before; lb1 cascades into lb0.
  sobel_line_buf #(.DEPTH(COL), .W(GRAY_W), .AW(XW)) u_lb1 (
    .clk   (clk),
    .we    (s1_vld),
    .addr  (s1_x),
    .wdata (s1_gray),
    .rdata (lb1_rd)
  );

  sobel_line_buf #(.DEPTH(COL), .W(GRAY_W), .AW(XW)) u_lb0 (
    .clk   (clk),
    .we    (s1_vld),
    .addr  (s1_x),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  // win[row][col]: row 0 is line y-2, col 2 is the newest pixel.
  logic [2:0][2:0][GRAY_W-1:0] win;
  logic                        s2_vld, s2_sop, s2_eop, s2_byp;
  logic [XW-1:0]               s2_x;
  logic [YW-1:0]               s2_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
      s2_vld <= 1'b0; s2_sop <= 1'b0; s2_eop <= 1'b0; s2_byp <= 1'b0;
      s2_x <= '0; s2_y <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        win[0] <= {lb0_rd,  win[0][2], win[0][1]};
        win[1] <= {lb1_rd,  win[1][2], win[1][1]};
        win[2] <= {s1_gray, win[2][2], win[2][1]};
        s2_sop <= s1_sop;
        s2_eop <= s1_eop;
        s2_byp <= s1_byp;
        s2_x   <= s1_x;
        s2_y   <= s1_y;
      end
    end
  end

  logic [9:0]        gx_p, gx_n, gy_p, gy_n;
  logic [GRAD_W-1:0] mag;

  always_comb begin
    gx_p = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
    gx_n = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
    gy_p = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
    gy_n = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
    mag  = abs_diff(gx_p, gx_n) + abs_diff(gy_p, gy_n);
  end

  logic              s3_vld, s3_sop, s3_eop, s3_byp, s3_border;
  logic [GRAD_W-1:0] s3_mag;
  logic [GRAY_W-1:0] s3_gray;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld <= 1'b0; s3_sop <= 1'b0; s3_eop <= 1'b0; s3_byp <= 1'b0;
      s3_border <= 1'b0; s3_mag <= '0; s3_gray <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_sop    <= s2_sop;
        s3_eop    <= s2_eop;
        s3_byp    <= s2_byp;
        // The window is incomplete (stale line or row data) in the first two rows/cols.
        s3_border <= (s2_x < XW'(2)) || (s2_y < YW'(2));
        s3_mag    <= mag;
        s3_gray   <= win[2][2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= BG_PIX; dout_vld <= 1'b0; dout_sop <= 1'b0; dout_eop <= 1'b0;
    end else begin
      dout_vld <= s3_vld;
      dout_sop <= s3_vld & s3_sop;
      dout_eop <= s3_vld & s3_eop;
      if (!s3_vld)     dout <= BG_PIX;
      else if (s3_byp) dout <= gray_to_565(s3_gray);
      else             dout <= (s3_border || s3_mag < THRESH) ? BG_PIX : EDGE_PIX;
    end
  end

endmodule
